fruit_gen: RTL and testbench

FRUIT_GEN -- requirements
Module: fruit_gen

---
 rtl/snake_pkg.sv | 31 +++
 rtl/fruit_gen_lfsr16.sv | 37 +++
 rtl/fruit_gen.sv | 142 ++++++++++++++
 tb/tb_fruit_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game peripherals: LFSR seed and taps,
// plus the bit layout of the fruit word that is returned on the bus.
package snake_pkg;

    // Power-on and "zero seed" replacement value for the fruit LFSR
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci taps 16,14,13,11 expressed as zero-based bit indices
    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    // Field positions inside the 32-bit fruit word {valid, 15'b0, x, y}
    localparam int FN_VALID_BIT = 31;
    localparam int FN_X_LSB     = 8;
    localparam int FN_Y_LSB     = 0;
    localparam int FN_COORD_W   = 8;

    // One queued fruit position
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } fruit_t;

    // One shift-left step with feedback into bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
    endfunction

endpackage

// File: rtl/fruit_gen_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and an all-zero lockup guard.
module lfsr16
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    // Step or load; a zero result is never allowed to reach the register
    always_comb begin
        lfsr_next = lfsr_step(lfsr_reg);
        if (load) begin
            lfsr_next = seed;
        end
        if (lfsr_next == 16'h0000) begin
            lfsr_next = LFSR_SEED;
        end
    end

    // State register, reset to the shared seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/fruit_gen.sv
// Fruit position generator: an LFSR proposes grid positions every cycle and
// accepted ones are queued in a small circular buffer that the CPU peeks
// and pops over the peripheral bus.
module fruit_gen
    import snake_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int GRID_X = 40,
    parameter int GRID_Y = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fruit_we,
    input  logic [4:0]                 fruit_addr,
    input  logic                       seed_we,
    input  logic [15:0]                seed_in,
    output logic [31:0]                fruit_next,
    output logic [$clog2(DEPTH):0]     fruit_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [15:0]    lfsr;
    fruit_t         cand;
    fruit_t         mem [DEPTH];

    logic [AW-1:0]  head_reg, head_next;
    logic [AW-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    fruit_t         last_reg, last_next;
    logic           last_valid_reg, last_valid_next;

    logic           pop;
    logic           push;
    logic           room;
    logic           cand_in_grid;
    logic           cand_new;

    logic [AW-1:0]  peek_off;
    logic [AW-1:0]  peek_idx;
    logic           peek_valid;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (seed_we),
        .seed  (seed_in),
        .value (lfsr)
    );

    // Candidate is taken straight from the current LFSR value
    assign cand.x = {2'b00, lfsr[5:0]};
    assign cand.y = {3'b000, lfsr[12:8]};

    // Bits of the LFSR and peek address that play no part in the datapath
    logic unused_bits;
    if (AW < 5) begin : g_addr_partial
        assign unused_bits = ^{fruit_addr[4:AW], lfsr[15:13], lfsr[7:6]};
    end else begin : g_addr_full
        assign unused_bits = ^{lfsr[15:13], lfsr[7:6]};
    end

    // Push/pop decision and next pointer/count state; a seed load flushes
    always_comb begin
        head_next       = head_reg;
        tail_next       = tail_reg;
        count_next      = count_reg;
        last_next       = last_reg;
        last_valid_next = last_valid_reg;

        pop          = fruit_we && (count_reg != '0) && !seed_we;
        // A pop from full frees the slot for a push on the same edge
        room         = (count_reg != CNT_W'(DEPTH)) || pop;
        cand_in_grid = (int'(cand.x) < GRID_X) && (int'(cand.y) < GRID_Y);
        cand_new     = !last_valid_reg || (cand != last_reg);
        push         = !seed_we && cand_in_grid && room && cand_new;

        if (seed_we) begin
            head_next       = '0;
            tail_next       = '0;
            count_next      = '0;
            last_valid_next = 1'b0;
        end else begin
            if (pop) begin
                head_next = head_reg + AW'(1);
            end
            if (push) begin
                tail_next       = tail_reg + AW'(1);
                last_next       = cand;
                last_valid_next = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Queue control registers; reset empties the queue without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            last_reg       <= '0;
            last_valid_reg <= 1'b0;
        end else begin
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            count_reg      <= count_next;
            last_reg       <= last_next;
            last_valid_reg <= last_valid_next;
        end
    end

    // Queue storage is never reset; only the tail slot is written on a push
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_reg] <= cand;
        end
    end

    // Peek path: only entries inside the live region report as valid
    assign peek_off   = fruit_addr[AW-1:0];
    assign peek_idx   = head_reg + peek_off;
    assign peek_valid = ({1'b0, peek_off} < count_reg);

    // Pack the peeked entry into the bus word layout
    always_comb begin
        fruit_next = '0;
        if (peek_valid) begin
            fruit_next[FN_VALID_BIT]             = 1'b1;
            fruit_next[FN_X_LSB +: FN_COORD_W]   = mem[peek_idx].x;
            fruit_next[FN_Y_LSB +: FN_COORD_W]   = mem[peek_idx].y;
        end
    end

    assign fruit_count = count_reg;

endmodule

// File: tb/tb_fruit_gen.sv
// Bench for fruit_gen: a queue-based reference model is compared against the
// DUT every cycle, and a few hand-computed literals pin the model itself.
module tb_fruit_gen;

    logic        clk;
    logic        rst;
    logic        fruit_we;
    logic [4:0]  fruit_addr;
    logic        seed_we;
    logic [15:0] seed_in;
    logic [31:0] fruit_next;
    logic [3:0]  fruit_count;

    int tests;
    int fails;

    fruit_gen #(.DEPTH(8), .GRID_X(40), .GRID_Y(30)) dut (
        .clk         (clk),
        .rst         (rst),
        .fruit_we    (fruit_we),
        .fruit_addr  (fruit_addr),
        .seed_we     (seed_we),
        .seed_in     (seed_in),
        .fruit_next  (fruit_next),
        .fruit_count (fruit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    logic [15:0] q[$];          // each entry {x[7:0], y[7:0]}
    logic [15:0] m_last;
    bit          m_last_valid;

    function automatic logic [15:0] model_next(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic [15:0] model_cand(input logic [15:0] v);
        logic [7:0] x;
        logic [7:0] y;
        x = 8'(v & 16'h003F);
        y = 8'((v >> 8) & 16'h001F);
        return {x, y};
    endfunction

    function automatic bit model_cand_ok(input logic [15:0] v);
        logic [15:0] c;
        c = model_cand(v);
        return (int'(c[15:8]) < 40) && (int'(c[7:0]) < 30) &&
               !(m_last_valid && (m_last == c));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr       = 16'hACE1;
            q.delete();
            m_last_valid = 0;
        end else if (seed_we) begin
            q.delete();
            m_last_valid = 0;
            m_lfsr       = (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
        end else begin
            logic [15:0] c;
            c = model_cand(m_lfsr);
            if (fruit_we && q.size() > 0) void'(q.pop_front());
            if (model_cand_ok(m_lfsr) && q.size() < 8) begin
                q.push_back(c);
                m_last       = c;
                m_last_valid = 1;
            end
            m_lfsr = model_next(m_lfsr);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [15:0] xy);
        return {1'b1, 15'b0, xy};
    endfunction

    // Per-cycle comparison of count and peeked word against the model
    always @(negedge clk) begin
        int off;
        logic [31:0] exp_next;
        #2;
        off = int'(fruit_addr[2:0]);
        exp_next = (off < q.size()) ? word_of(q[off]) : 32'h0;
        check("cycle_count", 32'(fruit_count), 32'(q.size()));
        check("cycle_next", fruit_next, exp_next);
    end

    task automatic step;
        @(negedge clk);
        #3;
    endtask

    task automatic wait_count(input int target, input int budget);
        int n;
        n = 0;
        while (int'(fruit_count) != target && n < budget) begin
            step();
            n++;
        end
        if (int'(fruit_count) != target)
            check("wait_count_timeout", 32'(fruit_count), 32'(target));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [15:0] snap1;
        logic [15:0] newc;
        int n;
        tests = 0;
        fails = 0;
        rst = 1'b1; fruit_we = 1'b0; fruit_addr = 5'd0; seed_we = 1'b0; seed_in = 16'h0;

        repeat (3) step();
        check("reset_count", 32'(fruit_count), 32'd0);
        check("reset_next", fruit_next, 32'h0);
        $display("[TB] reset state checked");

        // First candidate out of 0xACE1 is x=33, y=12; second from 0x59C3 is x=3, y=25
        rst = 1'b0;
        step();
        check("first_count", 32'(fruit_count), 32'd1);
        check("first_entry", fruit_next, 32'h8000_210C);
        step();
        fruit_addr = 5'd1;
        #1;
        check("second_entry", fruit_next, 32'h8000_0319);
        $display("[TB] first two pushes checked");

        // Fill without pops, then hold full for 20 clocks sweeping the peek address
        wait_count(8, 200);
        for (int i = 0; i < 20; i++) begin
            fruit_addr = 5'(i);          // upper address bits must be ignored
            step();
        end
        check("full_hold_count", 32'(fruit_count), 32'd8);
        $display("[TB] full queue hold checked");

        // Pop from full while the candidate is acceptable
        n = 0;
        while (!model_cand_ok(m_lfsr) && n < 100) begin
            step();
            n++;
        end
        if (!model_cand_ok(m_lfsr)) check("cand_wait_timeout", 32'd0, 32'd1);
        snap1 = q[1];
        newc  = model_cand(m_lfsr);
        fruit_we = 1'b1;
        step();
        fruit_we = 1'b0;
        check("pop_full_count", 32'(fruit_count), 32'd8);
        fruit_addr = 5'd0;
        #1;
        check("pop_full_head", fruit_next, word_of(snap1));
        fruit_addr = 5'd7;
        #1;
        check("pop_full_tail", fruit_next, word_of(newc));
        $display("[TB] pop from full checked");

        // Pop while held in reset is ignored
        rst = 1'b1;
        step();
        check("rst_count", 32'(fruit_count), 32'd0);
        fruit_we = 1'b1;
        step();
        fruit_we = 1'b0;
        check("rst_pop_count", 32'(fruit_count), 32'd0);
        check("rst_pop_next", fruit_next, 32'h0);
        rst = 1'b0;
        $display("[TB] pop on empty checked");

        // Peek beyond the live region reads as zero
        wait_count(3, 50);
        fruit_addr = 5'd5;
        #1;
        check("peek_past_count", fruit_next, 32'h0);
        fruit_addr = 5'd0;
        $display("[TB] peek past count checked");

        // Zero seed load with a simultaneous pop request: flush, LFSR back to 0xACE1
        wait_count(5, 50);
        seed_in  = 16'h0000;
        seed_we  = 1'b1;
        fruit_we = 1'b1;
        step();
        seed_we  = 1'b0;
        fruit_we = 1'b0;
        check("seed_flush_count", 32'(fruit_count), 32'd0);
        check("seed_flush_next", fruit_next, 32'h0);
        step();
        check("seed_first_count", 32'(fruit_count), 32'd1);
        check("seed_first_entry", fruit_next, 32'h8000_210C);
        $display("[TB] zero seed load checked");

        // Asynchronous reset between edges
        wait_count(6, 50);
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(fruit_count), 32'd0);
        check("async_rst_next", fruit_next, 32'h0);
        step();
        rst = 1'b0;
        $display("[TB] async reset checked");

        // Nonzero seed and mixed push/pop traffic, checked by the model
        seed_in = 16'h1234;
        seed_we = 1'b1;
        step();
        seed_we = 1'b0;
        for (int i = 0; i < 80; i++) begin
            fruit_we   = ((i % 3) == 0) || (i > 60);
            fruit_addr = 5'((i * 5) % 32);
            step();
        end
        fruit_we = 1'b0;
        $display("[TB] mixed traffic done");

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
